instr_fetch_queue: RTL and testbench

Program-loading instruction fetch front end for the SIMD pipeline. It holds the 25-bit instruction program in an internal memory filled over a load handshake. On `start` it streams the program in PC order through a small prefetch FIFO to the decode stage over a valid/ready handshake, so decode back-pressure never drops or duplicates an instruction. It sits directly upstream of the IF/ID pipeline register.

---
 rtl/simd_pkg.sv | 19 +
 rtl/instr_fetch_queue_if.sv | 40 ++++
 rtl/instr_fifo.sv | 68 ++++++
 rtl/instr_fetch_queue.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_pkg.sv
// Shared types for the SIMD front end.
//   INSTR_W       : instruction width (25 bits)
//   instr_t       : one instruction word
//   fetch_state_t : fetch-queue FSM states
package simd_pkg;

    localparam int INSTR_W = 25;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the load channel, the decode-facing output channel and status
// for instr_fetch_queue.
//   load_valid/load_ready/load_data/load_last : program load channel
//   start                                     : one-cycle fetch trigger
//   out_valid/out_ready/instr_out/pc_out      : instruction stream to decode
//   busy/done                                 : status
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its data stable while
// valid is high and ready is low; ready never depends on valid.
interface instr_fetch_queue_if #(
    parameter int PC_W = 6
);
    import simd_pkg::*;

    logic            load_valid;
    logic            load_ready;
    instr_t          load_data;
    logic            load_last;
    logic            start;
    logic            out_valid;
    logic            out_ready;
    instr_t          instr_out;
    logic [PC_W-1:0] pc_out;
    logic            busy;
    logic            done;

    // Driver side (loader / decode / controller).
    modport master (
        output load_valid, load_data, load_last, start, out_ready,
        input  load_ready, out_valid, instr_out, pc_out, busy, done
    );

    // Fetch queue side.
    modport slave (
        input  load_valid, load_data, load_last, start, out_ready,
        output load_ready, out_valid, instr_out, pc_out, busy, done
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous show-ahead FIFO of {pc, instruction} pairs.
//   clk, reset          : clock, asynchronous active-low reset
//   push/push_pc/push_instr : write entry (ignored when full without a pop)
//   pop                 : consume head entry (ignored when empty)
//   head_valid/head_pc/head_instr : current head, zero when empty
//   count               : number of stored entries (0..DEPTH)
module instr_fifo
    import simd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [PC_W-1:0]        push_pc,
    input  instr_t                 push_instr,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [PC_W-1:0]        head_pc,
    output instr_t                 head_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [PC_W-1:0] pc_mem    [DEPTH];
    instr_t          instr_mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count != '0);
    // A push into a full FIFO is allowed only when the head leaves this cycle.
    assign do_push = push && ((count != FULL) || do_pop);

    // Storage is not reset; the head is gated by head_valid instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wptr]    <= push_pc;
            instr_mem[wptr] <= push_instr;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_pc    = head_valid ? pc_mem[rptr]    : '0;
    assign head_instr = head_valid ? instr_mem[rptr] : '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// Program-loading instruction fetch front end. A program is written into the
// internal instruction memory over the load channel; a start pulse streams it
// in PC order through a prefetch FIFO to decode.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : load channel, start, output channel, busy/done (slave side)
//   dbg_state  : current FSM state
//   dbg_len    : stored program length in words
module instr_fetch_queue
    import simd_pkg::*;
#(
    parameter  int IMEM_DEPTH = 64,
    parameter  int FIFO_DEPTH = 4,
    localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_queue_if.slave   bus,
    output fetch_state_t         dbg_state,
    output logic [PC_W:0]        dbg_len
);

    localparam int LEN_W = PC_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(IMEM_DEPTH);
    localparam logic [LEN_W-1:0] LAST_ADDR = LEN_W'(IMEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [LEN_W-1:0] wptr_q;
    logic [LEN_W-1:0] len_q;
    logic [PC_W-1:0]  pc_q;
    logic             rd_valid_q;
    logic [PC_W-1:0]  rd_pc_q;
    instr_t           rd_instr_q;
    instr_t           imem [IMEM_DEPTH];

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_valid;
    logic [PC_W-1:0]  fifo_pc;
    instr_t           fifo_instr;

    logic load_acc;
    logic load_end;
    logic start_ok;
    logic issue;
    logic last_issue;
    logic pop;
    logic drain_done;

    // wptr reaches IMEM_DEPTH only when the memory has been filled; further
    // words are then refused until the program is started or reset.
    assign bus.load_ready = ((state_q == IDLE) || (state_q == LOAD) || (state_q == DONE))
                            && (wptr_q < DEPTH_L);
    assign load_acc = bus.load_valid && bus.load_ready;
    assign load_end = load_acc && (bus.load_last || (wptr_q == LAST_ADDR));
    // An accepted load word wins over a coincident start.
    assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE))
                      && (len_q != '0) && !load_acc;
    // The word in the read register counts against FIFO space so a stalled
    // decode can never overflow the FIFO.
    assign issue      = (state_q == FETCH) && ((fifo_count + CNT_W'(rd_valid_q)) < FIFO_FULL);
    assign last_issue = issue && ({1'b0, pc_q} == (len_q - 1'b1));
    assign pop        = fifo_valid && bus.out_ready;
    // Looks one cycle ahead so done rises the cycle after the final pop.
    assign drain_done = !rd_valid_q
                        && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    // FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (load_acc)      state_d = load_end ? IDLE : LOAD;
                else if (start_ok) state_d = FETCH;
            end
            LOAD:    if (load_end)   state_d = IDLE;
            FETCH:   if (last_issue) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        bus.busy  = (state_q == FETCH) || (state_q == DRAIN);
        bus.done  = (state_q == DONE);
        dbg_state = state_q;
    end

    // Instruction memory carries no reset; len=0 marks it empty.
    always_ff @(posedge clk) begin
        if (load_acc) imem[wptr_q[PC_W-1:0]] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            len_q      <= '0;
            pc_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_instr_q <= '0;
        end else begin
            if (load_end)      wptr_q <= (wptr_q == LAST_ADDR) ? DEPTH_L : '0;
            else if (load_acc) wptr_q <= wptr_q + 1'b1;
            else if (start_ok) wptr_q <= '0;

            if (load_end) len_q <= wptr_q + 1'b1;

            if (start_ok)   pc_q <= '0;
            else if (issue) pc_q <= pc_q + 1'b1;

            rd_valid_q <= issue;
            if (issue) begin
                rd_pc_q    <= pc_q;
                rd_instr_q <= imem[pc_q];
            end
        end
    end

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (rd_valid_q),
        .push_pc    (rd_pc_q),
        .push_instr (rd_instr_q),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_pc    (fifo_pc),
        .head_instr (fifo_instr),
        .count      (fifo_count)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.instr_out = fifo_instr;
    assign bus.pc_out    = fifo_pc;
    assign dbg_len       = len_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: loads programs, streams them out
// under varying decode back-pressure and compares against a scoreboard queue.
module tb_instr_fetch_queue;
    import simd_pkg::*;

    localparam int PC_W = 6;
    localparam int E_W  = PC_W + INSTR_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_queue_if #(.PC_W(PC_W)) bus ();
    fetch_state_t    dbg_state;
    logic [PC_W:0]   dbg_len;

    instr_fetch_queue #(
        .IMEM_DEPTH (64),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_len   (dbg_len)
    );

    // ---------------- scoreboard state ----------------
    logic [E_W-1:0] exp_q[$];
    logic [E_W-1:0] obs_q[$];
    int             obs_t[$];
    instr_t         prog[$];
    int             model_len;
    int             n_checks = 0;
    int             n_fail   = 0;
    int             first_valid;
    int             done_cyc;
    int             hold_bad;
    int             stall_count;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers prog[0..n-1]; gives up after 4 consecutive refused cycles.
    task automatic load_words(input int n, input bit use_last, output int accepted);
        int i;
        int idle;
        i = 0;
        idle = 0;
        accepted = 0;
        while (i < n && idle < 4) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            bus.load_last  = use_last && (i == n - 1);
            if (bus.load_ready) begin
                accepted++;
                i++;
                idle = 0;
            end else begin
                idle++;
            end
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic pulse_start(output int n_cyc);
        bus.start = 1'b1;
        n_cyc = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < model_len; i++) exp_q.push_back({PC_W'(i), prog[i]});
    endtask

    // Monitor: records every handshake on the output channel until done rises.
    // Holds out_ready low for stall_len cycles starting at the first valid.
    task automatic collect(input int stall_len, input int budget);
        logic [E_W-1:0] held;
        obs_q.delete();
        obs_t.delete();
        first_valid = -1;
        done_cyc    = -1;
        hold_bad    = 0;
        stall_count = -1;
        held        = '0;
        for (int k = 0; k < budget; k++) begin
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (first_valid >= 0 && cyc < first_valid + stall_len) begin
                bus.out_ready = 1'b0;
                if (cyc == first_valid) held = {bus.pc_out, bus.instr_out};
                else if (!bus.out_valid || ({bus.pc_out, bus.instr_out} !== held)) hold_bad++;
                if (cyc == first_valid + stall_len - 1) stall_count = int'(dut.fifo_count);
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back({bus.pc_out, bus.instr_out});
                obs_t.push_back(cyc);
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
        bus.out_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        n_checks++; if (bus.instr_out !== '0) begin n_fail++; $display("FAIL reset_instr_out got=%0h exp=0", bus.instr_out); end
        n_checks++; if (bus.pc_out !== '0) begin n_fail++; $display("FAIL reset_pc_out got=%0d exp=0", bus.pc_out); end
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got=%0b%0b exp=00", bus.busy, bus.done); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got=%0b exp=1", bus.load_ready); end
        n_checks++; if (dbg_state !== IDLE || dbg_len !== '0) begin n_fail++; $display("FAIL reset_state got=%0d len=%0d exp=IDLE len=0", dbg_state, dbg_len); end
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_start_ignored_idle();
        int n;
        pulse_start(n);
        n_checks++; if (bus.busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL start_no_prog got busy=%0b state=%0d exp busy=0 IDLE", bus.busy, dbg_state); end
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL start_no_prog_later got busy=%0b valid=%0b exp=0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_basic();
        int acc;
        int n;
        logic [E_W-1:0] want;
        prog.delete();
        for (int i = 1; i <= 5; i++) prog.push_back(INSTR_W'(i));
        model_len = 5;
        load_words(5, 1'b1, acc);
        n_checks++; if (acc !== 5) begin n_fail++; $display("FAIL basic_accepted got=%0d exp=5", acc); end
        n_checks++; if (dbg_len !== 7'd5) begin n_fail++; $display("FAIL basic_len got=%0d exp=5", dbg_len); end
        build_exp();
        pulse_start(n);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_n1 got=%0b exp=1", bus.busy); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL basic_load_ready_fetch got=%0b exp=0", bus.load_ready); end
        collect(0, 50);
        n_checks++; if (first_valid !== n + 3) begin n_fail++; $display("FAIL basic_first_valid got=%0d exp=%0d", first_valid, n + 3); end
        n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL basic_count got=%0d exp=5", obs_q.size()); end
        for (int i = 0; i < obs_t.size(); i++) begin
            n_checks++; if (obs_t[i] !== n + 3 + i) begin n_fail++; $display("FAIL basic_timing[%0d] got=%0d exp=%0d", i, obs_t[i], n + 3 + i); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++; if (obs_q[0] !== want) begin n_fail++; $display("FAIL basic_data got=%0h exp=%0h", obs_q[0], want); end
            void'(obs_q.pop_front());
        end
        n_checks++; if (done_cyc !== n + 8) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, n + 8); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_start_during_fetch();
        int n;
        logic [E_W-1:0] want;
        build_exp();
        pulse_start(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1 || dbg_state !== FETCH) begin n_fail++; $display("FAIL start_in_fetch got busy=%0b state=%0d exp busy=1 FETCH", bus.busy, dbg_state); end
        collect(0, 50);
        n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL start_in_fetch_count got=%0d exp=5", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++; if (obs_q[0] !== want) begin n_fail++; $display("FAIL start_in_fetch_data got=%0h exp=%0h", obs_q[0], want); end
            void'(obs_q.pop_front());
        end
        n_checks++; if (done_cyc !== n + 8) begin n_fail++; $display("FAIL start_in_fetch_done got=%0d exp=%0d", done_cyc, n + 8); end
    endtask

    task automatic test_replay_done();
        int n;
        logic [E_W-1:0] want;
        n_checks++; if (dbg_state !== DONE || bus.done !== 1'b1) begin n_fail++; $display("FAIL replay_pre_state got=%0d exp=DONE", dbg_state); end
        build_exp();
        pulse_start(n);
        collect(0, 50);
        n_checks++; if (first_valid !== n + 3) begin n_fail++; $display("FAIL replay_first_valid got=%0d exp=%0d", first_valid, n + 3); end
        n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL replay_count got=%0d exp=5", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++; if (obs_q[0] !== want) begin n_fail++; $display("FAIL replay_data got=%0h exp=%0h", obs_q[0], want); end
            void'(obs_q.pop_front());
        end
        n_checks++; if (done_cyc !== n + 8) begin n_fail++; $display("FAIL replay_done_cycle got=%0d exp=%0d", done_cyc, n + 8); end
    endtask

    task automatic test_stall();
        int n;
        logic [E_W-1:0] want;
        build_exp();
        pulse_start(n);
        collect(10, 80);
        n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL stall_hold got=%0d changes exp=0", hold_bad); end
        n_checks++; if (stall_count !== 4) begin n_fail++; $display("FAIL stall_buffered got=%0d exp=4", stall_count); end
        n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL stall_count got=%0d exp=5", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++; if (obs_q[0] !== want) begin n_fail++; $display("FAIL stall_data got=%0h exp=%0h", obs_q[0], want); end
            void'(obs_q.pop_front());
        end
        n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL stall_done got=timeout exp=done"); end
    endtask

    task automatic test_full_load();
        int acc;
        int n;
        logic [E_W-1:0] want;
        prog.delete();
        for (int i = 0; i < 70; i++) prog.push_back(INSTR_W'($urandom_range(0, 32'h01FF_FFFF)));
        model_len = 64;
        load_words(70, 1'b0, acc);
        n_checks++; if (acc !== 64) begin n_fail++; $display("FAIL full_accepted got=%0d exp=64", acc); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL full_load_ready got=%0b exp=0", bus.load_ready); end
        n_checks++; if (dbg_len !== 7'd64) begin n_fail++; $display("FAIL full_len got=%0d exp=64", dbg_len); end
        build_exp();
        pulse_start(n);
        collect(0, 200);
        n_checks++; if (obs_q.size() !== 64) begin n_fail++; $display("FAIL full_count got=%0d exp=64", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++; if (obs_q[0] !== want) begin n_fail++; $display("FAIL full_data got=%0h exp=%0h", obs_q[0], want); end
            void'(obs_q.pop_front());
        end
        n_checks++; if (done_cyc !== n + 67) begin n_fail++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc, n + 67); end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.out_ready = 1'b0;
        pulse_start(n);
        repeat (4) tick();
        n_checks++; if (int'(dut.fifo_count) !== 3 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre got count=%0d valid=%0b exp=3 1", dut.fifo_count, bus.out_valid); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got valid=%0b busy=%0b exp=0 0", bus.out_valid, bus.busy); end
        n_checks++; if (dbg_state !== IDLE || dbg_len !== '0) begin n_fail++; $display("FAIL midreset_state got=%0d len=%0d exp=IDLE 0", dbg_state, dbg_len); end
        n_checks++; if (bus.instr_out !== '0) begin n_fail++; $display("FAIL midreset_instr got=%0h exp=0", bus.instr_out); end
        #2;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        pulse_start(n);
        n_checks++; if (bus.busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL midreset_start got busy=%0b state=%0d exp=0 IDLE", bus.busy, dbg_state); end
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_later got busy=%0b valid=%0b exp=0 0", bus.busy, bus.out_valid); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.start      = 1'b0;
        bus.out_ready  = 1'b1;
        test_reset();
        test_start_ignored_idle();
        test_basic();
        test_start_during_fetch();
        test_replay_done();
        test_stall();
        test_full_load();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
